sync_frame_tx: RTL and testbench
================================

Name: sync_frame_tx

Overview:
Serial frame transmitter for the 1011-sync serial link. It accepts a parallel payload word through a valid/ready handshake. It then emits one bit per clock: the fixed sync word 1011, followed by the payload MSB-first. Zero-stuffing guarantees that 1011 never appears in the stream after the sync word, so an overlapping 1011 detector on the far end fires only on the frame start. The block sits on the transmit side of the link, driving the line that feeds the receiver's sync detector.

Parameters:
DATA_W, 8, payload width in bits (legal range 2..32)
GAP, 2, number of idle line cycles after each frame before the next frame can be accepted (legal range 2..15)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, asynchronous, active-high
start_valid  in  1  payload offered
start_ready  out  1  block can accept a payload
data_in  in  DATA_W  payload word, sampled on handshake
tx_bit  out  1  serial line bit (registered)
tx_en  out  1  tx_bit carries a frame bit this cycle (registered)
busy  out  1  frame or gap in progress
frame_done  out  1  one-cycle pulse coincident with the last frame bit
stuff_cnt  out  5  number of stuffed bits in the current or last frame; cleared on accept

Behaviour:
- Reset: the asynchronous rst drives the FSM to IDLE. Outputs take these values: start_ready=1, tx_bit=0, tx_en=0, busy=0, frame_done=0, stuff_cnt=0. The internal payload shift register and the match tracker are cleared.
- Reset asserted mid-frame aborts the frame immediately. No completion pulse is issued.
- Handshake:
  - Accept occurs when start_valid && start_ready.
  - start_ready=1 only in IDLE.
  - start_valid outside IDLE is ignored, and data_in is not re-sampled.
  - On accept: data_in is latched, the tracker is set to T0, and stuff_cnt is cleared.
- FSM states:
  - IDLE: line at 0, tx_en=0. Go to SYNC on accept.
  - SYNC: 4 cycles; tx_bit = 1,0,1,1 in order with tx_en=1. The first sync bit appears in the cycle after accept.
  - DATA: one payload bit per cycle, MSB first, tx_en=1.
  - STUFF: one cycle, tx_bit=0, tx_en=1; stuff_cnt increments.
  - GAP: GAP cycles with tx_bit=0, tx_en=0, busy=1. Then go to IDLE.
- Match tracker: a 5-state exact suffix tracker for pattern 1011, advanced on every transmitted frame bit (sync, payload and stuff bits).
  - T0: on 0 stay T0; on 1 go to T1.
  - T1 (suffix 1): on 1 stay T1; on 0 go to T10.
  - T10 (suffix 10): on 1 go to T101; on 0 go to T0.
  - T101 (suffix 101): on 1 go to T1011; on 0 go to T10.
  - T1011: on 1 go to T1; on 0 go to T10.
  - After SYNC the tracker is always T1011.
- Stuffing rule:
  - After any payload bit leaves the tracker in T101, the next transmitted bit is a stuffed 0, unconditionally. The receiver drops it by the same rule.
  - This also applies after the last payload bit: a trailing stuff bit is sent before GAP.
  - Consequence: the tracker never reaches T1011 after SYNC.
- Frame length is 4 + DATA_W + stuff_cnt cycles.
  - Stuffed bits are at most DATA_W-1, so the maximum frame length is 3 + 2*DATA_W cycles.
  - stuff_cnt saturates at 31.
- busy=1 from the cycle after accept through the last GAP cycle.
- frame_done=1 in the cycle of the last tx_en=1 bit: the last payload bit, or the trailing stuff bit if one is sent.
- Back-to-back frames: the earliest next accept is in the first IDLE cycle after GAP. Throughput is one frame per (frame length + GAP + 1) cycles.

Test Plan:
- Reset then data_in=8'hFF accepted: tx_bit stream 1011_11111111 with tx_en=1 for 12 cycles; stuff_cnt=0; frame_done on cycle 12; tx_en=0 for 2 gap cycles; start_ready=1 on the following cycle.
- data_in=8'hAA: stream 1011 1 0 1 [0] 0 1 0 1 [0] 0, 14 frame bits; stuff_cnt=2; no 1011 appears in a golden overlapping detector after the sync word.
- Worst case data_in=8'h7F: stream 1011 0 1 [0] followed by 1 [0] six times, 19 frame bits; stuff_cnt=7; the trailing stuff bit carries frame_done.
- start_valid held high continuously with data 8'hAA then 8'h55: the second accept occurs exactly in the first IDLE cycle after GAP; data_in changes mid-frame do not alter the first frame.
- rst pulsed during the payload of 8'hAA: outputs at reset values within the same cycle, no frame_done; a new frame after release is well-formed.
- Random payloads (DATA_W=8 and 16) fed to a golden unstuffer: recovered data equals sent data; the detector fires exactly once per frame, on the 4th sync bit.

Source files
------------

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial transmitter emitting sync word 1011 then an MSB-first payload,
// zero-stuffed so that 1011 never reappears after the sync word.
module sync_frame_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done,
  output logic [4:0]        stuff_cnt
);
  localparam int SW = DATA_W + 3;
  localparam logic [5:0] DW = 6'(DATA_W);
  localparam logic [5:0] RL = 6'(SW);
  localparam logic [5:0] GL = 6'(GAP - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, GAP_S} state_t;
  typedef enum logic [2:0] {T0, T1, T10, T101, T1011} trk_t;

  function automatic trk_t adv(input trk_t t, input logic b);
    case (t)
      T0:      adv = b ? T1 : T0;
      T1:      adv = b ? T1 : T10;
      T10:     adv = b ? T101 : T0;
      T101:    adv = b ? T1011 : T10;
      default: adv = b ? T1 : T10;
    endcase
  endfunction

  state_t        state_q, state_d;
  trk_t          trk_q, trk_d, trk_nx;
  logic [SW-1:0] sh_q, sh_d;
  logic [5:0]    rem_q, rem_d;
  logic [4:0]    stuff_cnt_q, stuff_cnt_d;
  logic          tx_bit_q, tx_bit_d, tx_en_q, tx_en_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          accept, need_stuff, nb;

  // sh_q holds the bits still to send after the one on the line; rem_q counts them
  // (and counts down the gap cycles in GAP_S). trk_q excludes the bit on the line.
  always_comb begin
    accept      = start_valid && state_q == IDLE;
    trk_nx      = tx_en_q ? adv(trk_q, tx_bit_q) : trk_q;
    need_stuff  = state_q == DATA && trk_nx == T101;
    nb          = sh_q[SW-1];
    state_d     = state_q;
    trk_d       = trk_nx;
    sh_d        = sh_q;
    rem_d       = rem_q;
    stuff_cnt_d = stuff_cnt_q;
    tx_bit_d    = 1'b0;
    tx_en_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d     = SYNC;
        trk_d       = T0;
        sh_d        = {3'b011, data_in};
        rem_d       = RL;
        stuff_cnt_d = 5'd0;
        tx_bit_d    = 1'b1;
        tx_en_d     = 1'b1;
        busy_d      = 1'b1;
      end
      GAP_S: if (rem_q == 6'd0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else rem_d = rem_q - 6'd1;
      default: if (need_stuff) begin
        state_d     = STUFF;
        tx_en_d     = 1'b1;
        stuff_cnt_d = stuff_cnt_q == 5'd31 ? stuff_cnt_q : stuff_cnt_q + 5'd1;
        done_d      = rem_q == 6'd0;
      end else if (rem_q == 6'd0) begin
        state_d = GAP_S;
        rem_d   = GL;
      end else begin
        // the last payload bit ends the frame unless it forces a trailing stuff bit
        state_d  = rem_q > DW ? SYNC : DATA;
        tx_bit_d = nb;
        tx_en_d  = 1'b1;
        sh_d     = {sh_q[SW-2:0], 1'b0};
        rem_d    = rem_q - 6'd1;
        done_d   = rem_q == 6'd1 && adv(trk_nx, nb) != T101;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trk_q       <= T0;
      sh_q        <= '0;
      rem_q       <= 6'd0;
      stuff_cnt_q <= 5'd0;
      tx_bit_q    <= 1'b0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trk_q       <= trk_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      stuff_cnt_q <= stuff_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_en_q     <= tx_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign start_ready = state_q == IDLE;
  assign tx_bit      = tx_bit_q;
  assign tx_en       = tx_en_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign stuff_cnt   = stuff_cnt_q;
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: frame-level model plus golden unstuffer/detector checks of sync_frame_tx.
module tb_sync_frame_tx;
  localparam int GAP8 = 2;

  logic       clk = 1'b0, rst, start_valid, start_ready, tx_bit, tx_en, busy, frame_done;
  logic [7:0] data_in;
  logic [4:0] stuff_cnt;
  logic        v16, rdy16, b16, en16, busy16, done16;
  logic [15:0] d16;
  logic [4:0]  st16;

  int n_chk = 0, n_fail = 0;

  sync_frame_tx #(.DATA_W(8), .GAP(GAP8)) u8 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .data_in(data_in), .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy),
    .frame_done(frame_done), .stuff_cnt(stuff_cnt));

  sync_frame_tx #(.DATA_W(16), .GAP(3)) u16 (
    .clk(clk), .rst(rst), .start_valid(v16), .start_ready(rdy16),
    .data_in(d16), .tx_bit(b16), .tx_en(en16), .busy(busy16),
    .frame_done(done16), .stuff_cnt(st16));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Frame from the rules: sync word, payload MSB first, a 0 after any payload bit
  // that leaves the last three line bits at 101. sm marks stuffed positions.
  function automatic void build(input logic [7:0] d, output logic [31:0] bits,
                                output logic [31:0] sm, output int len, output int st);
    logic [3:0] sy;
    sy = 4'b1011; bits = 0; sm = 0; len = 0; st = 0;
    for (int i = 3; i >= 0; i--) begin
      bits = {bits[30:0], sy[i]}; sm = {sm[30:0], 1'b0}; len++;
    end
    for (int i = 7; i >= 0; i--) begin
      bits = {bits[30:0], d[i]}; sm = {sm[30:0], 1'b0}; len++;
      if (bits[2:0] == 3'b101) begin
        bits = {bits[30:0], 1'b0}; sm = {sm[30:0], 1'b1}; len++; st++;
      end
    end
  endfunction

  typedef struct packed {
    logic b, en, busy, done, ready;
    logic [4:0] st;
  } ent_t;

  function automatic ent_t mk(input logic b, en, bz, dn, rd, input logic [4:0] st);
    ent_t e;
    e.b = b; e.en = en; e.busy = bz; e.done = dn; e.ready = rd; e.st = st;
    return e;
  endfunction

  ent_t exp_e;
  ent_t q[$];

  // model: per-cycle expected outputs queued at each predicted accept
  always begin : model
    logic [31:0] bits, sm;
    int len, st, s;
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      exp_e = mk(0, 0, 0, 0, 1, 0);
    end else begin
      if (exp_e.ready && start_valid) begin
        build(data_in, bits, sm, len, st);
        s = 0;
        for (int k = len - 1; k >= 0; k--) begin
          s += int'(sm[k]);
          q.push_back(mk(bits[k], 1, 1, k == 0, 0, 5'(s)));
        end
        for (int k = 0; k < GAP8; k++) q.push_back(mk(0, 0, 1, 0, 0, 5'(s)));
      end
      if (q.size() > 0) exp_e = q.pop_front();
      else exp_e = mk(0, 0, 0, 0, 1, exp_e.st);
    end
  end

  always begin : cmp
    @(negedge clk);
    check("tx_bit", 32'(tx_bit), 32'(exp_e.b));
    check("tx_en", 32'(tx_en), 32'(exp_e.en));
    check("busy", 32'(busy), 32'(exp_e.busy));
    check("frame_done", 32'(frame_done), 32'(exp_e.done));
    check("start_ready", 32'(start_ready), 32'(exp_e.ready));
    check("stuff_cnt", 32'(stuff_cnt), 32'(exp_e.st));
  end

  logic [31:0] cap = 0;
  logic [3:0]  h8 = 0;
  logic        prev_en = 0;
  int cap_len = 0, done_at = 0, done_cnt = 0, good8 = 0, bad8 = 0, cyc = 0;
  int acc_q[$];

  always begin : cap_p
    @(negedge clk);
    cyc++;
    if (start_valid && start_ready && !rst) acc_q.push_back(cyc);
    if (tx_en) begin
      if (!prev_en) begin cap = 0; cap_len = 0; h8 = 0; end
      cap = {cap[30:0], tx_bit}; cap_len++; h8 = {h8[2:0], tx_bit};
      if (cap_len >= 4 && h8 == 4'b1011) begin
        if (cap_len == 4) good8++; else bad8++;
      end
      if (frame_done) done_at = cap_len;
    end
    if (frame_done) done_cnt++;
    prev_en = tx_en;
  end

  logic [15:0] exp16[$];
  logic [15:0] word16 = 0;
  logic [3:0]  h16 = 0;
  logic        prev16 = 0, pend16 = 0;
  int n16 = 0, nb16 = 0, hits16 = 0, s16 = 0, frames16 = 0;

  // golden receiver for the 16-bit instance: drop the bit after any 101 payload suffix
  always begin : unstuff
    @(negedge clk);
    if (en16) begin
      if (!prev16) begin
        n16 = 0; h16 = 0; word16 = 0; nb16 = 0; pend16 = 0; hits16 = 0; s16 = 0;
      end
      n16++; h16 = {h16[2:0], b16};
      check("busy16", 32'(busy16), 1);
      if (n16 >= 4 && h16 == 4'b1011) begin hits16++; check("det16_pos", n16, 4); end
      if (n16 > 4) begin
        if (pend16) begin check("stuff16_zero", 32'(b16), 0); pend16 = 0; s16++; end
        else begin word16 = {word16[14:0], b16}; nb16++; pend16 = h16[2:0] == 3'b101; end
      end
      if (done16) begin
        if (exp16.size() > 0) check("unstuff16_data", 32'(word16), 32'(exp16.pop_front()));
        else check("unstuff16_extra_frame", 1, 0);
        check("unstuff16_bits", nb16, 16);
        check("unstuff16_trailing", 32'(pend16), 0);
        check("det16_hits", hits16, 1);
        check("stuff_cnt16", 32'(st16), s16);
        frames16++;
      end
    end
    prev16 = en16;
  end

  task automatic send8(input logic [7:0] d);
    start_valid = 1; data_in = d;
    step();
    start_valid = 0; data_in = ~d;
  endtask

  task automatic wait8();
    int n = 0;
    step();
    while (!start_ready && n < 200) begin step(); n++; end
    if (!start_ready) begin
      n_chk++; n_fail++;
      $display("FAIL wait8_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic wait16();
    int n = 0;
    step();
    while (!rdy16 && n < 200) begin step(); n++; end
    if (!rdy16) begin
      n_chk++; n_fail++;
      $display("FAIL wait16_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic frame_chk(input string name, input int len, input logic [31:0] bits, input int st);
    check({name, "_len"}, cap_len, len);
    check({name, "_bits"}, cap, bits);
    check({name, "_done_at"}, done_at, len);
    check({name, "_stuff"}, 32'(stuff_cnt), 32'(st));
  endtask

  task automatic reset_chk(input string name);
    check({name, "_ready"}, 32'(start_ready), 1);
    check({name, "_tx_bit"}, 32'(tx_bit), 0);
    check({name, "_tx_en"}, 32'(tx_en), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(frame_done), 0);
    check({name, "_stuff"}, 32'(stuff_cnt), 0);
  endtask

  initial begin
    logic [31:0] bits, sm;
    int len, st, a0, n, d0;
    logic [15:0] dv;
    rst = 1; start_valid = 0; data_in = 0; v16 = 0; d16 = 0;
    repeat (2) step();
    reset_chk("reset");
    rst = 0;
    step();

    build(8'hFF, bits, sm, len, st);
    check("model_ff_len", len, 12); check("model_ff_bits", bits, 'hBFF); check("model_ff_st", st, 0);
    build(8'hAA, bits, sm, len, st);
    check("model_aa_len", len, 14); check("model_aa_bits", bits, 'h2E94); check("model_aa_st", st, 2);
    build(8'h7F, bits, sm, len, st);
    check("model_7f_len", len, 19); check("model_7f_bits", bits, 'h5AAAA); check("model_7f_st", st, 7);

    send8(8'hFF); wait8(); frame_chk("ff", 12, 'hBFF, 0);
    send8(8'hAA); wait8(); frame_chk("aa", 14, 'h2E94, 2);
    send8(8'h7F); wait8(); frame_chk("7f", 19, 'h5AAAA, 7);

    a0 = acc_q.size();
    start_valid = 1; data_in = 8'hAA;
    step();
    data_in = 8'h55;
    n = 0;
    while (acc_q.size() < a0 + 2 && n < 100) begin step(); n++; end
    start_valid = 0;
    if (acc_q.size() >= a0 + 2) check("b2b_period", acc_q[a0+1] - acc_q[a0], 17);
    else check("b2b_second_accept", 32'(acc_q.size()), 32'(a0 + 2));
    wait8(); frame_chk("b2b_55", 14, 'h2D29, 2);

    d0 = done_cnt;
    send8(8'hAA);
    repeat (6) step();
    rst = 1;
    #1;
    reset_chk("midrst");
    check("midrst_no_done", done_cnt, d0);
    @(posedge clk); #3;
    rst = 0;
    step();
    send8(8'h3C); wait8(); frame_chk("after_rst", 12, 'hB3C, 0);
    check("after_rst_done_cnt", done_cnt, d0 + 1);

    for (int i = 0; i < 8; i++) begin send8(8'($urandom)); wait8(); end

    for (int i = 0; i < 12; i++) begin
      dv = i == 0 ? 16'h7FFF : i == 1 ? 16'hAAAA : 16'($urandom);
      v16 = 1; d16 = dv; exp16.push_back(dv);
      step();
      v16 = 0; d16 = ~dv;
      wait16();
    end

    check("det8_extra", bad8, 0);
    check("det8_sync", good8, acc_q.size());
    check("frames16", frames16, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
